// File: rtl/fifo_sync_fwft.sv
// fifo_sync_fwft: single-clock first-word-fall-through FIFO with occupancy
// count, almost-full/almost-empty flags and synchronous flush.
// Define FIFO_ERR_EN to build the sticky overflow/underflow flags.
module fifo_sync_fwft #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int AFULL_LVL  = (1 << ADDR_WIDTH) - 2,
    parameter int AEMPTY_LVL = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_LVL);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_LVL);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = (ADDR_WIDTH)'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  rd_acc;
    logic                  wr_acc;

    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_C);
    assign almost_full  = (count_q >= AFULL_C);
    assign almost_empty = (count_q <= AEMPTY_C);
    assign count        = count_q;

    // A write into a full FIFO is only safe when the head leaves this cycle.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    // Head word falls through; masked to zero so stale storage never leaks.
    assign data_out = empty ? '0 : mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy; flush overrides both requests.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (wr_acc && !rd_acc) count_d = count_q + CNT_ONE;
            if (rd_acc && !wr_acc) count_d = count_q - CNT_ONE;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_acc && !flush) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

`ifdef FIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error flags; flush wins over a same-cycle set.
    always_comb begin
        overflow_d  = overflow_q | (wr_en && !wr_acc);
        underflow_d = underflow_q | (rd_en && empty);
        if (flush) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    // Error flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sync_fwft.sv
// tb_fifo_sync_fwft: directed stimulus with a scoreboard queue of
// expected pops, checked by an independent read monitor.
module tb_fifo_sync_fwft;

    localparam int DW = 32;
    localparam int AW = 3;

`ifdef FIFO_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          wr_en;
    logic [DW-1:0] data_in;
    logic          rd_en;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] exp_q[$];

    fifo_sync_fwft #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .AFULL_LVL(6),
        .AEMPTY_LVL(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .wr_en(wr_en),
        .data_in(data_in),
        .rd_en(rd_en),
        .data_out(data_out),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .count(count),
        .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [DW-1:0] a,
                       input logic [DW-1:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", n, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string n, input int c, input logic ef,
                             input logic ff, input logic aef, input logic aff);
        chk({n, "_count"}, DW'(count), DW'(c));
        chk({n, "_empty"}, DW'(empty), DW'(ef));
        chk({n, "_full"}, DW'(full), DW'(ff));
        chk({n, "_aempty"}, DW'(almost_empty), DW'(aef));
        chk({n, "_afull"}, DW'(almost_full), DW'(aff));
    endtask

    // Read monitor: a pop will be accepted at the coming edge, so the
    // head word shown now must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && rd_en && !empty && !flush) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_unexpected act=%0h exp=none", data_out);
            end else begin
                chk("pop_data", data_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_flags("rst", 0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("rst_dout", data_out, 32'h0);
        chk("rst_ovf", DW'(overflow), 32'h0);
        chk("rst_unf", DW'(underflow), 32'h0);
        rst = 1'b0;
        tick();

        // Fill 0x11..0x88 and watch the flags step.
        for (int i = 1; i <= 8; i++) begin
            wr_en = 1'b1;
            data_in = DW'(i * 'h11);
            exp_q.push_back(DW'(i * 'h11));
            tick();
            chk_flags($sformatf("fill%0d", i), i, 1'b0, i == 8, i <= 1, i >= 6);
            chk("fill_head", data_out, 32'h11);
        end
        wr_en = 1'b0;

        // Drain all eight.
        rd_en = 1'b1;
        repeat (8) tick();
        rd_en = 1'b0;
        chk_flags("drain", 0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("drain_dout", data_out, 32'h0);

        // Refill, then write and read together while full.
        for (int i = 1; i <= 8; i++) begin
            wr_en = 1'b1;
            data_in = DW'(i * 'h11);
            exp_q.push_back(DW'(i * 'h11));
            tick();
        end
        data_in = 32'h99;
        rd_en = 1'b1;
        exp_q.push_back(32'h99);
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk_flags("wr_rd_full", 8, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("wr_rd_full_head", data_out, 32'h22);
        rd_en = 1'b1;
        repeat (8) tick();
        rd_en = 1'b0;
        chk_flags("drain2", 0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Simultaneous write and read on empty: no bypass.
        wr_en = 1'b1;
        rd_en = 1'b1;
        data_in = 32'hAB;
        exp_q.push_back(32'hAB);
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk_flags("wr_rd_empty", 1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("wr_rd_empty_dout", data_out, 32'hAB);
        chk("wr_rd_empty_unf", DW'(underflow), DW'(ERR));
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("pop_ab_count", DW'(count), 32'h0);

        // Five entries, then flush with a concurrent write.
        for (int i = 1; i <= 5; i++) begin
            wr_en = 1'b1;
            data_in = DW'(i);
            tick();
        end
        chk("pre_flush_count", DW'(count), 32'h5);
        flush = 1'b1;
        data_in = 32'hEE;
        tick();
        flush = 1'b0;
        wr_en = 1'b0;
        chk_flags("flush", 0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("flush_dout", data_out, 32'h0);
        chk("flush_ovf", DW'(overflow), 32'h0);
        chk("flush_unf", DW'(underflow), 32'h0);

        // Nine writes with no reads: ninth is rejected.
        for (int i = 1; i <= 9; i++) begin
            wr_en = 1'b1;
            data_in = DW'(i);
            if (i <= 8) exp_q.push_back(DW'(i));
            tick();
            chk($sformatf("ovf_w%0d", i), DW'(overflow),
                DW'(ERR && i == 9));
        end
        wr_en = 1'b0;
        tick();
        chk("ovf_sticky", DW'(overflow), DW'(ERR));
        chk("ovf_count", DW'(count), 32'h8);
        rd_en = 1'b1;
        repeat (8) tick();
        rd_en = 1'b0;
        chk("ovf_drain_empty", DW'(empty), 32'h1);
        chk("ovf_sticky2", DW'(overflow), DW'(ERR));

        // Asynchronous reset mid-operation.
        for (int i = 1; i <= 3; i++) begin
            wr_en = 1'b1;
            data_in = DW'(i + 'h40);
            tick();
        end
        wr_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_flags("arst", 0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("arst_dout", data_out, 32'h0);
        chk("arst_ovf", DW'(overflow), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("arst_hold", DW'(count), 32'h0);

        chk("sb_left", DW'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
